// File: rtl/riscv_pipe_pkg.sv
// Shared MEM-stage types: FSM state encoding and the
// ResultSrc code that marks a load.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_t;

  localparam logic [1:0] RESULTSRC_MEM = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Ports: clk, reset (sync, active-low), clr, en, q (count value).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage req/ack sequencer with pipeline stall, bubble injection
// and a saturating stall-cycle counter.
// Ports: clk, reset (sync, active-low); EX/MEM inputs MemWriteM,
// ResultSrcM, ALUResultM, WriteDataM; memory side mem_req/we/addr/
// wdata/ack/rdata; pipeline side ReadDataM, StallMem, FlushW;
// status stall_cnt, mem_err.
// Optional macro MEM_TIMEOUT_EN: abort a request after
// TIMEOUT_CYCLES cycles in WAIT and raise sticky mem_err.
module mem_stage_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        FlushW,
  output logic [31:0] stall_cnt,
  output logic        mem_err
);

  if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES does not fit in CNT_W bits");
  end

  mem_state_t  state;
  mem_state_t  state_nx;
  logic        access;
  logic        timeout;
  logic        abort;
  logic [31:0] rdata_q;

  assign access    = MemWriteM | (ResultSrcM == RESULTSRC_MEM);
  assign mem_we    = MemWriteM;
  assign mem_addr  = ALUResultM;
  assign mem_wdata = WriteDataM;

  // Reset kills the request at once, even mid-transaction.
  assign mem_req  = reset &
                    (((state == IDLE) & access) | (state == WAIT));
  assign StallMem = mem_req & ~mem_ack;
  assign FlushW   = StallMem | abort;

  assign ReadDataM = mem_ack ? mem_rdata : rdata_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (access && !mem_ack) state_nx = WAIT;
      WAIT: begin
        if (mem_ack)      state_nx = IDLE;
        else if (timeout) state_nx = ERR;
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (mem_req && mem_ack && !mem_we) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  sat_counter #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (StallMem),
    .q     (stall_cnt)
  );

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] tcnt;

  // tcnt holds WAIT cycles already spent, so the last allowed
  // WAIT cycle is the one seeing TIMEOUT_CYCLES-1.
  assign timeout = (state == WAIT) & ~mem_ack &
                   (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // The ERR cycle lets EX/MEM advance while the bubble drops it.
  assign abort   = reset & (state == ERR);

  sat_counter #(.W(CNT_W)) u_tcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_nx == IDLE),
    .en    (state == WAIT),
    .q     (tcnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_err <= 1'b0;
    end else if (timeout) begin
      mem_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign abort   = 1'b0;
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: vector table plus
// reset-in-WAIT and timeout / long-wait sequences.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ReadDataM;
  logic        StallMem;
  logic        FlushW;
  logic [31:0] stall_cnt;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ReadDataM  (ReadDataM),
    .StallMem   (StallMem),
    .FlushW     (FlushW),
    .stall_cnt  (stall_cnt),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [1:0]  rs;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic        we;
    logic        stall;
    logic        flush;
    logic [31:0] rd;
    logic [31:0] cnt;
  } vec_t;

  vec_t v[15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic mw, input logic [1:0] rs,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic ack, input logic [31:0] rdt);
    MemWriteM  = mw;
    ResultSrcM = rs;
    ALUResultM = a;
    WriteDataM = wd;
    mem_ack    = ack;
    mem_rdata  = rdt;
  endtask

  initial begin
    // idle
    v[0]  = '{0, 2'b00, 32'h0,   32'h0, 0, 32'h0,
              0, 0, 0, 0, 32'h0, 0};
    // load 0x40, ack three cycles after first req
    v[1]  = '{0, 2'b01, 32'h40,  32'h0, 0, 32'h0,
              1, 0, 1, 1, 32'h0, 0};
    v[2]  = '{0, 2'b01, 32'h40,  32'h0, 0, 32'h0,
              1, 0, 1, 1, 32'h0, 1};
    v[3]  = '{0, 2'b01, 32'h40,  32'h0, 0, 32'h0,
              1, 0, 1, 1, 32'h0, 2};
    v[4]  = '{0, 2'b01, 32'h40,  32'h0, 1, 32'hDEADBEEF,
              1, 0, 0, 0, 32'hDEADBEEF, 3};
    v[5]  = '{0, 2'b00, 32'h0,   32'h0, 0, 32'h0,
              0, 0, 0, 0, 32'hDEADBEEF, 3};
    // zero-wait store
    v[6]  = '{1, 2'b00, 32'h100, 32'h12345678, 1, 32'h0,
              1, 1, 0, 0, 32'h0, 3};
    v[7]  = '{0, 2'b00, 32'h0,   32'h0, 0, 32'h0,
              0, 0, 0, 0, 32'hDEADBEEF, 3};
    // stray ack with no request
    v[8]  = '{0, 2'b00, 32'h0,   32'h0, 1, 32'hAAAA5555,
              0, 0, 0, 0, 32'hAAAA5555, 3};
    v[9]  = '{0, 2'b00, 32'h0,   32'h0, 0, 32'h0,
              0, 0, 0, 0, 32'hDEADBEEF, 3};
    // back-to-back loads, 1-cycle latency each
    v[10] = '{0, 2'b01, 32'h200, 32'h0, 0, 32'h0,
              1, 0, 1, 1, 32'hDEADBEEF, 3};
    v[11] = '{0, 2'b01, 32'h200, 32'h0, 1, 32'h11111111,
              1, 0, 0, 0, 32'h11111111, 4};
    v[12] = '{0, 2'b01, 32'h204, 32'h0, 0, 32'h0,
              1, 0, 1, 1, 32'h11111111, 4};
    v[13] = '{0, 2'b01, 32'h204, 32'h0, 1, 32'h22222222,
              1, 0, 0, 0, 32'h22222222, 5};
    v[14] = '{0, 2'b00, 32'h0,   32'h0, 0, 32'h0,
              0, 0, 0, 0, 32'h22222222, 5};

    // reset with a load present: outputs held low
    reset = 1'b0;
    drive(0, 2'b01, 32'h40, 32'h0, 0, 32'h0);
    @(negedge clk);
    #1;
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_stall", {31'b0, StallMem}, 0);
    chk("rst_flush", {31'b0, FlushW}, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
    #1;
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_rd", ReadDataM, 0);
    chk("rst_err", {31'b0, mem_err}, 0);
    chk("rst_idle_req", {31'b0, mem_req}, 0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(v[i].mw, v[i].rs, v[i].addr, v[i].wdata,
            v[i].ack, v[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, mem_req},
          {31'b0, v[i].req});
      chk($sformatf("v%0d_we", i), {31'b0, mem_we},
          {31'b0, v[i].we});
      chk($sformatf("v%0d_stall", i), {31'b0, StallMem},
          {31'b0, v[i].stall});
      chk($sformatf("v%0d_flush", i), {31'b0, FlushW},
          {31'b0, v[i].flush});
      chk($sformatf("v%0d_rd", i), ReadDataM, v[i].rd);
      chk($sformatf("v%0d_cnt", i), stall_cnt, v[i].cnt);
      chk($sformatf("v%0d_addr", i), mem_addr, v[i].addr);
      chk($sformatf("v%0d_wdata", i), mem_wdata, v[i].wdata);
    end
    chk("tbl_err", {31'b0, mem_err}, 0);

    // reset asserted in the second (WAIT) cycle of a load
    @(negedge clk);
    drive(0, 2'b01, 32'h300, 32'h0, 0, 32'h0);
    #1;
    chk("rw_req0", {31'b0, mem_req}, 1);
    @(negedge clk);
    #1;
    chk("rw_req1", {31'b0, mem_req}, 1);
    chk("rw_stall1", {31'b0, StallMem}, 1);
    reset = 1'b0;
    #1;
    chk("rw_req_drop", {31'b0, mem_req}, 0);
    chk("rw_stall_drop", {31'b0, StallMem}, 0);
    chk("rw_flush_drop", {31'b0, FlushW}, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
    #1;
    chk("rw_idle_req", {31'b0, mem_req}, 0);
    chk("rw_idle_stall", {31'b0, StallMem}, 0);
    chk("rw_cnt", stall_cnt, 0);

`ifdef MEM_TIMEOUT_EN
    @(negedge clk);
    drive(0, 2'b01, 32'h400, 32'h0, 0, 32'h0);
    #1;
    chk("to_req0", {31'b0, mem_req}, 1);
    chk("to_stall0", {31'b0, StallMem}, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("to_wait%0d_req", k), {31'b0, mem_req}, 1);
      chk($sformatf("to_wait%0d_err", k), {31'b0, mem_err}, 0);
    end
    @(negedge clk);
    #1;
    chk("to_abort_req", {31'b0, mem_req}, 0);
    chk("to_abort_stall", {31'b0, StallMem}, 0);
    chk("to_abort_flush", {31'b0, FlushW}, 1);
    chk("to_abort_err", {31'b0, mem_err}, 1);
    @(negedge clk);
    drive(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
    #1;
    chk("to_post_flush", {31'b0, FlushW}, 0);
    chk("to_post_req", {31'b0, mem_req}, 0);
    chk("to_cnt", stall_cnt, 5);
    repeat (3) @(negedge clk);
    #1;
    chk("to_err_sticky", {31'b0, mem_err}, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("to_err_cleared", {31'b0, mem_err}, 0);
`else
    begin
      int bad;
      bad = 0;
      @(negedge clk);
      drive(0, 2'b01, 32'h500, 32'h0, 0, 32'h0);
      for (int c = 0; c < 1000; c++) begin
        #1;
        if (StallMem !== 1'b1) bad++;
        @(negedge clk);
      end
      #1;
      chk("long_stall_hold", bad, 0);
      chk("long_cnt", stall_cnt, 1000);
      chk("long_err", {31'b0, mem_err}, 0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      #1;
      chk("long_ack_stall", {31'b0, StallMem}, 0);
      chk("long_ack_rd", ReadDataM, 32'hCAFEF00D);
      @(negedge clk);
      drive(0, 2'b00, 32'h0, 32'h0, 0, 32'h0);
      #1;
      chk("long_done_req", {31'b0, mem_req}, 0);
      chk("long_done_rd", ReadDataM, 32'hCAFEF00D);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Sequencing controller for the MEM stage of the five-stage RISC-V pipeline. It sits beside the EX/MEM pipeline register and turns the load/store held in that register into a req/ack transaction to a variable-latency data memory. While the transaction is outstanding it freezes the upstream pipeline and injects bubbles into the MEM/WB register. It also keeps a saturating count of memory stall cycles.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: wait-cycle limit before abort. Used only with MEM_TIMEOUT_EN.
- CNT_W, 8: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- MemWriteM  in  1  store in MEM stage.
- ResultSrcM  in  2  2'b01 marks a load.
- ALUResultM  in  32  effective address.
- WriteDataM  in  32  store data.
- mem_req  out  1  request to data memory.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  32  = ALUResultM.
- mem_wdata  out  32  = WriteDataM.
- mem_ack  in  1  memory completes the request this cycle.
- mem_rdata  in  32  load data; valid when mem_ack = 1.
- ReadDataM  out  32  load data to the MEM/WB register.
- StallMem  out  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- FlushW  out  1  load zeros (bubble) into the MEM/WB register.
- stall_cnt  out  32  saturating count of StallMem cycles.
- mem_err  out  1  sticky timeout flag. Tied to 0 without MEM_TIMEOUT_EN.

## Operation
- access = MemWriteM | (ResultSrcM == 2'b01). mem_we = MemWriteM.
- FSM states: IDLE, WAIT, and ERR (ERR exists only with the macro).
- mem_req = (IDLE & access) | WAIT. It is combinational.
- StallMem = mem_req & ~mem_ack.
- FlushW = StallMem | abort. abort is the single cycle of the WAIT→ERR transition.
- ReadDataM = mem_rdata when mem_ack, else the last captured load data register.
- Load data is captured on every cycle where mem_req & mem_ack & ~mem_we.
- Transitions:
  - IDLE→WAIT: access & ~mem_ack.
  - IDLE stays IDLE: zero-wait ack, or no access.
  - WAIT→IDLE: mem_ack.
  - WAIT→ERR: timeout (macro only).
  - ERR→IDLE: next cycle.
- The address, wdata and we outputs are stable for the whole transaction, because StallMem holds EX/MEM.
- mem_ack while mem_req = 0 is ignored.
- stall_cnt increments on each StallMem cycle and saturates at 32'hFFFF_FFFF.

## Timing
- Reset (reset = 0 at a clock edge) gives: state IDLE, capture register 0, stall_cnt 0, mem_err 0, timeout counter 0.
  - During reset, mem_req, StallMem and FlushW are forced to 0.
- Reset during WAIT drops mem_req immediately. The memory must tolerate an abandoned request.
- Zero-wait memory (ack in the first req cycle) costs 0 stall cycles.
- An ack N cycles after the first req costs N stall cycles.
  - The pipeline advances on the edge that ends the ack cycle.
  - ReadDataM is valid in that ack cycle.
- Back-to-back accesses: the next access may issue req in the cycle immediately after an ack.
- FlushW is high on exactly the cycles StallMem is high, plus the abort cycle.

## Configuration
- MEM_TIMEOUT_EN defined:
  - The timeout counter counts cycles spent in WAIT.
  - When the count reaches TIMEOUT_CYCLES without an ack, the FSM enters ERR. In that cycle mem_req = 0, StallMem = 0 and FlushW = 1, so the instruction is dropped.
  - mem_err sets and stays 1 until reset.
  - The counter clears on entering IDLE.
- MEM_TIMEOUT_EN undefined:
  - WAIT lasts indefinitely.
  - No counter and no ERR state are built; mem_err = 0.

## Structure
- Package riscv_pipe_pkg holds:
  - the mem_state_t enum (IDLE, WAIT, ERR);
  - RESULTSRC_MEM = 2'b01.
- Sub-module sat_counter (parameterised width, increment enable, synchronous clear, saturate at all-ones).
  - It is instantiated for stall_cnt.
  - It is also instantiated for the timeout counter, under the macro.

## Test plan
- Load at 0x0000_0040, ack at cycle 3 after req, rdata 0xDEAD_BEEF:
  - StallMem = FlushW = 1 for 3 cycles.
  - ReadDataM = 0xDEAD_BEEF in the ack cycle.
  - stall_cnt = 3.
- Store to 0x100 with data 0x1234_5678, ack in the same cycle as req:
  - mem_we = 1, no stall, FSM stays IDLE.
- Two consecutive loads, each with 1-cycle latency:
  - req is deasserted for no cycle between them.
  - stall_cnt = 2.
- reset = 0 asserted in WAIT (2nd cycle):
  - The next cycle has mem_req = 0, StallMem = 0, stall_cnt = 0 and the FSM in IDLE.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, load with ack never asserted:
  - mem_req drops after 4 WAIT cycles.
  - FlushW pulses on the abort cycle.
  - mem_err = 1 and stays 1 until reset.
- Without MEM_TIMEOUT_EN and no ack for 1000 cycles:
  - StallMem stays 1 throughout, mem_err = 0, stall_cnt = 1000.
